// File: rtl/vtg_piso_reader_pkg.sv
// Shared definitions for the parallel-in serial-out reader: FSM state encodings
// and the divider width helper.
package vtg_piso_reader_pkg;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   // Width of the bit-period divider: at least one bit, even when CLK_DIV is 1 or 2.
   function automatic int unsigned div_width(int unsigned div);
      if (div <= 2) begin
         return 1;
      end
      return $clog2(div);
   endfunction

endpackage

// File: rtl/vtg_piso_reader.sv
// Captures a SIZE-bit word on start and streams it out one bit at a time, each
// bit held for CLK_DIV cycles, with a start/busy/done handshake toward the
// requester and valid/strobe qualifiers toward the serial consumer.
module vtg_piso_reader
   import vtg_piso_reader_pkg::*;
#(
   parameter int unsigned SIZE      = 8,
   parameter int unsigned MSB_FIRST = 1,
   parameter int unsigned CLK_DIV   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] datain,
   output logic            busy,
   output logic            sdata,
   output logic            svalid,
   output logic            bit_stb,
   output logic            done
);

   localparam int unsigned CntW = $clog2(SIZE + 1);
   localparam int unsigned DivW = div_width(CLK_DIV);

   localparam logic [CntW-1:0] CntLoad = CntW'(SIZE);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [DivW-1:0] DivOne  = DivW'(1);

   logic [1:0]      state_q, state_d;
   logic [SIZE-1:0] sr_q, sr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DivW-1:0] div_q, div_d;

   // Next-state logic: capture on accepted start, shift at the end of each bit period.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      case (state_q)
         // DONE accepts start exactly like IDLE so frames can run back-to-back.
         StIdle, StDone: begin
            if (start) begin
               sr_d    = datain;
               cnt_d   = CntLoad;
               div_d   = '0;
               state_d = StShift;
            end else begin
               state_d = StIdle;
            end
         end
         StShift: begin
            if (div_q == DivLast) begin
               div_d = '0;
               cnt_d = cnt_q - CntOne;
               // Vacated positions fill with zero.
               if (MSB_FIRST != 0) begin
                  sr_d = sr_q << 1;
               end else begin
                  sr_d = sr_q >> 1;
               end
               if (cnt_q == CntOne) begin
                  state_d = StDone;
               end
            end else begin
               div_d = div_q + DivOne;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; synchronous reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sr_q    <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
      end
   end

   // Outputs decode only registered state, so start/datain never reach them combinationally.
   always_comb begin
      busy    = (state_q == StShift);
      svalid  = (state_q == StShift);
      bit_stb = (state_q == StShift) && (div_q == '0);
      done    = (state_q == StDone);
      sdata   = 1'b0;
      if (state_q == StShift) begin
         sdata = (MSB_FIRST != 0) ? sr_q[SIZE-1] : sr_q[0];
      end
   end

endmodule

// File: tb/tb_vtg_piso_reader.sv
// Directed bench for vtg_piso_reader: four instances with different parameter
// sets, a table of per-cycle vectors plus a hand-written CLK_DIV=3 sequence.
module tb_vtg_piso_reader;

   logic       clk;
   logic       rst;
   logic       start_v [4];
   logic [7:0] din_v   [4];
   logic       busy_w  [4];
   logic       sdata_w [4];
   logic       svalid_w[4];
   logic       stb_w   [4];
   logic       done_w  [4];

   int checks = 0;
   int errors = 0;

   // {busy, svalid, sdata, bit_stb, done}
   typedef struct {
      int         dut;
      logic       rst;
      logic       start;
      logic [7:0] din;
      logic [4:0] exp;
      string      name;
      int         cyc;
   } vec_t;

   vec_t vq[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vtg_piso_reader #(.SIZE(8), .MSB_FIRST(1), .CLK_DIV(1)) u_def (
      .clk(clk), .rst(rst), .start(start_v[0]), .datain(din_v[0]),
      .busy(busy_w[0]), .sdata(sdata_w[0]), .svalid(svalid_w[0]),
      .bit_stb(stb_w[0]), .done(done_w[0])
   );

   vtg_piso_reader #(.SIZE(8), .MSB_FIRST(0), .CLK_DIV(1)) u_lsb (
      .clk(clk), .rst(rst), .start(start_v[1]), .datain(din_v[1]),
      .busy(busy_w[1]), .sdata(sdata_w[1]), .svalid(svalid_w[1]),
      .bit_stb(stb_w[1]), .done(done_w[1])
   );

   vtg_piso_reader #(.SIZE(8), .MSB_FIRST(1), .CLK_DIV(3)) u_div3 (
      .clk(clk), .rst(rst), .start(start_v[2]), .datain(din_v[2]),
      .busy(busy_w[2]), .sdata(sdata_w[2]), .svalid(svalid_w[2]),
      .bit_stb(stb_w[2]), .done(done_w[2])
   );

   vtg_piso_reader #(.SIZE(1), .MSB_FIRST(1), .CLK_DIV(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start_v[3]), .datain(din_v[3][0:0]),
      .busy(busy_w[3]), .sdata(sdata_w[3]), .svalid(svalid_w[3]),
      .bit_stb(stb_w[3]), .done(done_w[3])
   );

   function automatic logic [4:0] obs(int d);
      return {busy_w[d], svalid_w[d], sdata_w[d], stb_w[d], done_w[d]};
   endfunction

   function automatic logic [4:0] sh(logic b);
      return {1'b1, 1'b1, b, 1'b1, 1'b0};
   endfunction

   function automatic void add(int dut, logic r, logic s, logic [7:0] din, logic [4:0] exp,
                               string name, int cyc);
      vec_t v;
      v.dut   = dut;
      v.rst   = r;
      v.start = s;
      v.din   = din;
      v.exp   = exp;
      v.name  = name;
      v.cyc   = cyc;
      vq.push_back(v);
   endfunction

   task automatic check(string name, int cyc, logic [4:0] act, logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: {busy,svalid,sdata,stb,done} got %b want %b",
                  name, cyc, act, exp);
      end
   endtask

   localparam logic [4:0] Idle = 5'b00000;
   localparam logic [4:0] Done = 5'b00001;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] w;
      logic [7:0] w2;
      logic [4:0] e;
      int         k;

      rst = 1'b1;
      for (int d = 0; d < 4; d++) begin
         start_v[d] = 1'b0;
         din_v[d]   = 8'h00;
      end
      repeat (2) @(posedge clk);

      // Reset state on every instance.
      for (int d = 0; d < 4; d++) add(d, 1'b1, 1'b0, 8'h00, Idle, "reset", 0);

      // Default parameters, 0xB4 MSB first.
      w = 8'hB4;
      add(0, 1'b0, 1'b1, w, Idle, "def", 0);
      for (int i = 0; i < 8; i++) add(0, 1'b0, 1'b0, w, sh(w[7-i]), "def", i + 1);
      add(0, 1'b0, 1'b0, w, Done, "def", 9);
      add(0, 1'b0, 1'b0, w, Idle, "def", 10);

      // LSB first.
      add(1, 1'b0, 1'b1, w, Idle, "lsb", 0);
      for (int i = 0; i < 8; i++) add(1, 1'b0, 1'b0, w, sh(w[i]), "lsb", i + 1);
      add(1, 1'b0, 1'b0, w, Done, "lsb", 9);
      add(1, 1'b0, 1'b0, w, Idle, "lsb", 10);

      // start held high, datain changed mid-frame; second frame starts in DONE.
      add(0, 1'b0, 1'b1, w, Idle, "b2b", 0);
      for (int i = 0; i < 8; i++) add(0, 1'b0, 1'b1, 8'hFF, sh(w[7-i]), "b2b", i + 1);
      add(0, 1'b0, 1'b1, 8'hFF, Done, "b2b", 9);
      for (int i = 0; i < 8; i++) add(0, 1'b0, 1'b0, 8'hFF, sh(1'b1), "b2b", i + 10);
      add(0, 1'b0, 1'b0, 8'hFF, Done, "b2b", 18);
      add(0, 1'b0, 1'b0, 8'hFF, Idle, "b2b", 19);

      // Reset mid-frame, then a clean frame.
      w2 = 8'h5A;
      add(0, 1'b0, 1'b1, w, Idle, "rstmid", 0);
      for (int i = 0; i < 3; i++) add(0, 1'b0, 1'b0, w, sh(w[7-i]), "rstmid", i + 1);
      add(0, 1'b1, 1'b0, w, sh(w[4]), "rstmid", 4);
      add(0, 1'b0, 1'b0, w, Idle, "rstmid", 5);
      add(0, 1'b0, 1'b0, w, Idle, "rstmid", 6);
      add(0, 1'b0, 1'b1, w2, Idle, "rstmid", 7);
      for (int i = 0; i < 8; i++) add(0, 1'b0, 1'b0, w2, sh(w2[7-i]), "rstmid", i + 8);
      add(0, 1'b0, 1'b0, w2, Done, "rstmid", 16);
      add(0, 1'b0, 1'b0, w2, Idle, "rstmid", 17);

      // SIZE=1: single-bit frames with datain 1 then 0.
      add(3, 1'b0, 1'b1, 8'h01, Idle, "size1", 0);
      add(3, 1'b0, 1'b0, 8'h01, sh(1'b1), "size1", 1);
      add(3, 1'b0, 1'b0, 8'h01, Done, "size1", 2);
      add(3, 1'b0, 1'b0, 8'h01, Idle, "size1", 3);
      add(3, 1'b0, 1'b1, 8'h00, Idle, "size1", 4);
      add(3, 1'b0, 1'b0, 8'h00, sh(1'b0), "size1", 5);
      add(3, 1'b0, 1'b0, 8'h00, Done, "size1", 6);
      add(3, 1'b0, 1'b0, 8'h00, Idle, "size1", 7);

      foreach (vq[n]) begin
         @(posedge clk);
         #1;
         rst = vq[n].rst;
         for (int d = 0; d < 4; d++) start_v[d] = (d == vq[n].dut) ? vq[n].start : 1'b0;
         din_v[vq[n].dut] = vq[n].din;
         @(negedge clk);
         check(vq[n].name, vq[n].cyc, obs(vq[n].dut), vq[n].exp);
      end

      // CLK_DIV=3, 0x81: each bit held three cycles, strobe on the first of each.
      w = 8'h81;
      for (int c = 0; c < 27; c++) begin
         @(posedge clk);
         #1;
         rst        = 1'b0;
         start_v[2] = (c == 0);
         din_v[2]   = w;
         @(negedge clk);
         if (c >= 1 && c <= 24) begin
            k = (c - 1) / 3;
            e = {1'b1, 1'b1, w[7-k], ((c - 1) % 3 == 0), 1'b0};
         end else if (c == 25) begin
            e = Done;
         end else begin
            e = Idle;
         end
         check("div3", c, obs(2), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vtg_piso_reader.md
Name: vtg_piso_reader

Overview:
Read-side companion to the team's parallel-load registers: captures a SIZE-bit word on request and streams it out bit-serially.
- Start/busy/done handshake toward the requester.
- Per-bit valid and strobe toward the serial consumer.
- Programmable bit order and bit period.
- Used wherever register contents must leave the chip or cross to a narrow link.

Parameters:
- SIZE, 8, word width in bits (>=1)
- MSB_FIRST, 1, 1 = bit SIZE-1 sent first; 0 = bit 0 sent first
- CLK_DIV, 1, clk cycles each bit is held on sdata (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high
- start  input  1  request to capture datain and send; sampled on clk
- datain  input  SIZE  word to send; sampled only on an accepted start
- busy  output  1  frame in progress; start ignored while high
- sdata  output  1  current serial bit
- svalid  output  1  sdata holds a valid frame bit
- bit_stb  output  1  one-cycle pulse on the first cycle of each bit
- done  output  1  one-cycle pulse after the last bit period

Behaviour:
- Reset (rst high at an edge) forces: busy=0, sdata=0, svalid=0, bit_stb=0, done=0, state IDLE, counters 0.
- Reset wins over every other input, including mid-frame. The frame is abandoned and done is not pulsed.
- FSM states:
  - IDLE: outputs 0. start=1 captures datain into the shift register, loads the bit counter with SIZE and the divider with 0, then goes to SHIFT.
  - SHIFT: busy=1, svalid=1. sdata = shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0). The divider counts 0..CLK_DIV-1.
    - bit_stb=1 when divider==0.
    - When divider==CLK_DIV-1: shift by one, decrement the bit counter, reset the divider.
    - If the decremented count reaches 0, go to DONE.
  - DONE: one cycle. done=1, busy=0, svalid=0, sdata=0. start=1 here is accepted exactly as in IDLE (back-to-back frames), and the next state is SHIFT. Otherwise the next state is IDLE.
- Latency:
  - start sampled at edge N puts the first bit on sdata in the cycle after edge N.
  - The frame occupies SIZE*CLK_DIV cycles.
  - done is high for the single cycle following the last bit cycle.
  - Back-to-back frames have a gap of exactly 1 cycle (the DONE cycle).
- start while busy=1 is ignored, with no effect on the shift register or counters.
- datain changes after capture do not affect the frame in flight.
- CLK_DIV=1: bit_stb is high on every SHIFT cycle.
- SIZE=1: the frame is a single bit.
- Counter widths:
  - Bit counter is $clog2(SIZE+1).
  - Divider is max(1,$clog2(CLK_DIV)).
  - No wrap-around is reachable in legal operation.
- Shift register fill bits are 0.
- All outputs are registered; no combinational path from start or datain to any output.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a clog2 helper if the toolflow lacks $clog2.
- No sub-module is required. The shift register, bit counter and divider are inline.
- A separate divider/strobe generator (vtg_strobe_div) is the only natural split, if reuse elsewhere is wanted.

Test Plan:
- Default params (SIZE=8, MSB_FIRST=1, CLK_DIV=1), datain=0xB4, start pulse at cycle 0:
  - sdata = 1,0,1,1,0,1,0,0 on cycles 1-8.
  - svalid and busy high on cycles 1-8, bit_stb high on cycles 1-8.
  - done high on cycle 9 only.
- MSB_FIRST=0, datain=0xB4 -> sdata = 0,0,1,0,1,1,0,1 on cycles 1-8.
- CLK_DIV=3, datain=0x81:
  - Each bit held 3 cycles; bit_stb on cycles 1,4,...,22.
  - done on cycle 25.
- start held high, with datain changed to 0xFF during the frame:
  - The frame still sends the captured 0xB4.
  - The second frame starts in the DONE cycle (cycle 9), with first bit on cycle 10 carrying the 0xFF sampled at that edge.
- rst asserted at cycle 4 mid-frame:
  - All outputs are 0 from cycle 5 and no done pulse occurs.
  - A new start at cycle 7 sends a full clean frame.
- SIZE=1, datain=1 -> sdata=1 on cycle 1, done on cycle 2.
